// File: rtl/mbinit_sb_tx_arbiter.sv
// Round-robin arbiter sharing the MBINIT sideband TX message port between sub-step requesters.
// Define MBINIT_SB_ARB_FIXED_PRIO_EN to switch to fixed lowest-index-wins priority.
module mbinit_sb_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int SB_MSG_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                            CLK,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                i_req_valid,
    input  logic [N_REQ*SB_MSG_WIDTH-1:0]   i_req_msg,
    input  logic                            i_Busy_SideBand,
    input  logic                            i_falling_edge_busy,
    output logic [SB_MSG_WIDTH-1:0]         o_TX_SbMessage,
    output logic                            o_ValidOutDatat,
    output logic [N_REQ-1:0]                o_grant,
    output logic [N_REQ-1:0]                o_req_done,
    output logic                            o_timeout
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SB_MSG_WIDTH-1:0] tx_d;
    logic                    vld_d;
    logic [N_REQ-1:0]        grant_d, done_d;
    logic                    to_d;
    logic [IDX_W-1:0]        sel;

`ifdef MBINIT_SB_ARB_FIXED_PRIO_EN
    function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] req);
        logic [IDX_W-1:0] s;
        s = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (req[k]) s = IDX_W'(k);
        return s;
    endfunction
`else
    logic [IDX_W-1:0] last_q, last_d, owner_q, owner_d;

    // Walk from last+N down to last+1 so the nearest requester after last wins.
    function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] req,
                                              input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] s;
        int               idx;
        s = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % N_REQ;
            if (req[idx]) s = IDX_W'(idx);
        end
        return s;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = o_TX_SbMessage;
        vld_d   = 1'b0;
        grant_d = o_grant;
        done_d  = '0;
        to_d    = 1'b0;
        sel     = '0;
`ifndef MBINIT_SB_ARB_FIXED_PRIO_EN
        owner_d = owner_q;
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                grant_d = '0;
                tx_d    = '0;
                if (|i_req_valid && !i_Busy_SideBand) begin
`ifdef MBINIT_SB_ARB_FIXED_PRIO_EN
                    sel = pick(i_req_valid);
`else
                    sel     = pick(i_req_valid, last_q);
                    owner_d = sel;
`endif
                    grant_d = ONE_HOT0 << sel;
                    tx_d    = i_req_msg[sel*SB_MSG_WIDTH +: SB_MSG_WIDTH];
                    vld_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            // A falling edge seen here belongs to earlier traffic and is ignored.
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_falling_edge_busy || cnt_q >= CNT_LAST) begin
                    done_d  = i_falling_edge_busy ? o_grant : '0;
                    to_d    = !i_falling_edge_busy;
                    grant_d = '0;
                    tx_d    = '0;
                    state_d = IDLE;
`ifndef MBINIT_SB_ARB_FIXED_PRIO_EN
                    last_d  = owner_q;
`endif
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                tx_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            o_TX_SbMessage  <= '0;
            o_ValidOutDatat <= 1'b0;
            o_grant         <= '0;
            o_req_done      <= '0;
            o_timeout       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            o_TX_SbMessage  <= tx_d;
            o_ValidOutDatat <= vld_d;
            o_grant         <= grant_d;
            o_req_done      <= done_d;
            o_timeout       <= to_d;
        end
    end

`ifndef MBINIT_SB_ARB_FIXED_PRIO_EN
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            last_q  <= IDX_W'(N_REQ - 1);
            owner_q <= '0;
        end else begin
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end
`endif

endmodule

// File: tb/tb_mbinit_sb_tx_arbiter.sv
// Scoreboard bench for mbinit_sb_tx_arbiter: stimulus pushes expected grants, a monitor checks them.
module tb_mbinit_sb_tx_arbiter;
    localparam int N = 4;
    localparam int W = 4;
    localparam int T = 8;
`ifdef MBINIT_SB_ARB_FIXED_PRIO_EN
    localparam int RR = 0;
`else
    localparam int RR = 1;
`endif

    logic           CLK = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_msg;
    logic           busy, fe;
    logic [W-1:0]   tx_msg;
    logic           tx_vld, timeout;
    logic [N-1:0]   grant, req_done;

    mbinit_sb_tx_arbiter #(.N_REQ(N), .SB_MSG_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .rst(rst), .i_req_valid(req_valid), .i_req_msg(req_msg),
        .i_Busy_SideBand(busy), .i_falling_edge_busy(fe),
        .o_TX_SbMessage(tx_msg), .o_ValidOutDatat(tx_vld), .o_grant(grant),
        .o_req_done(req_done), .o_timeout(timeout)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int           strobe_cyc;
        int           done_cyc;
        logic [N-1:0] grant;
        logic [W-1:0] msg;
        bit           is_to;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   active = 1'b0;
    bit   stim_done = 1'b0;
    int   n_chk = 0, n_pass = 0;
    int   last;

    // Reference arbitration: first requester at or after the search start, modulo N.
    function automatic int winner(input logic [N-1:0] m, input int lst);
        int start = ((lst + 1) * RR) % N;
        for (int j = 0; j < N; j++)
            if (m[(start + j) % N]) return (start + j) % N;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge CLK) begin
        if (rst) begin
            chk("reset_outputs", int'({tx_msg, tx_vld, grant, req_done, timeout}), 0);
            active = 1'b0;
        end else begin
            if (tx_vld) begin
                if (q.size() == 0) chk("unexpected_strobe", 1, 0);
                else begin
                    cur = q.pop_front();
                    active = 1'b1;
                    chk("strobe_cycle", cyc, cur.strobe_cyc);
                    chk("strobe_grant", int'(grant), int'(cur.grant));
                    chk("strobe_msg", int'(tx_msg), int'(cur.msg));
                end
            end else if (req_done != '0 || timeout) begin
                if (!active) chk("unexpected_completion", int'({req_done, timeout}), 0);
                else begin
                    chk("complete_cycle", cyc, cur.done_cyc);
                    chk("complete_done", int'(req_done), cur.is_to ? 0 : int'(cur.grant));
                    chk("complete_timeout", int'(timeout), int'(cur.is_to));
                    chk("complete_grant", int'(grant), 0);
                    active = 1'b0;
                end
            end else if (active) begin
                if (cyc > cur.done_cyc) begin
                    chk("missing_completion", cyc, cur.done_cyc);
                    active = 1'b0;
                end else begin
                    chk("grant_hold", int'(grant), int'(cur.grant));
                    chk("msg_hold", int'(tx_msg), int'(cur.msg));
                end
            end else begin
                chk("idle_grant", int'(grant), 0);
            end
            if (stim_done || cyc > 50000) begin
                chk("stim_finished", int'(stim_done), 1);
                chk("queue_empty", q.size(), 0);
                chk("no_pending", int'(active), 0);
                $display("%0d/%0d checks passed", n_pass, n_chk);
                $finish;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that shows the completion pulse.
    task automatic txn(input logic [N-1:0] mask, input logic [N*W-1:0] msgs, input int busy_cyc,
                       input int fe_k, input bit fe_issue, input bit scramble);
        exp_t e;
        int   w;
        int   span;
        req_valid = mask;
        req_msg   = msgs;
        fe        = 1'b0;
        busy      = (busy_cyc > 0);
        for (int i = 0; i < busy_cyc; i++) begin
            @(posedge CLK); #1;
        end
        busy = 1'b0;
        w    = winner(mask, last);
        span = (fe_k == 0) ? T : fe_k;
        e.strobe_cyc = cyc + 1;
        e.done_cyc   = cyc + 2 + span;
        e.grant      = N'(1) << w;
        e.msg        = msgs[w*W +: W];
        e.is_to      = (fe_k == 0);
        q.push_back(e);
        @(posedge CLK); #1;
        busy = 1'b1;
        fe   = fe_issue;
        for (int k = 1; k <= span; k++) begin
            @(posedge CLK); #1;
            fe = (k == fe_k);
            if (k == fe_k) busy = 1'b0;
            if (scramble) begin
                req_valid = N'($urandom);
                req_msg   = (N*W)'($urandom);
            end
        end
        @(posedge CLK); #1;
        fe   = 1'b0;
        busy = 1'b0;
        last = w;
    endtask

    task automatic reset_mid(input logic [N-1:0] mask);
        exp_t e;
        int   w;
        req_valid = mask;
        req_msg   = (N*W)'($urandom);
        busy      = 1'b0;
        fe        = 1'b0;
        w = winner(mask, last);
        e.strobe_cyc = cyc + 1;
        e.done_cyc   = cyc + 2 + T;
        e.grant      = N'(1) << w;
        e.msg        = req_msg[w*W +: W];
        e.is_to      = 1'b1;
        q.push_back(e);
        @(posedge CLK); #1;
        busy = 1'b1;
        repeat (2) begin
            @(posedge CLK); #1;
        end
        rst       = 1'b1;
        req_valid = '0;
        busy      = 1'b0;
        repeat (2) @(posedge CLK);
        #1 rst = 1'b0;
        last = N - 1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_msg   = '0;
        busy      = 1'b0;
        fe        = 1'b0;
        last      = N - 1;
        repeat (3) @(posedge CLK);
        #1 rst = 1'b0;

        txn(4'b0010, 16'h0010, 0, 4, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) txn(4'b1111, (N*W)'($urandom), 0, 3, 1'b0, 1'b0);
        txn(4'b0001, (N*W)'($urandom), 10, 2, 1'b0, 1'b0);
        txn(4'b0110, (N*W)'($urandom), 0, 0, 1'b0, 1'b1);
        txn(4'b1011, (N*W)'($urandom), 0, 3, 1'b1, 1'b0);
        txn(4'b1111, (N*W)'($urandom), 0, T, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++)
            txn(N'($urandom_range(1, 15)), (N*W)'($urandom), $urandom_range(0, 3),
                $urandom_range(0, T), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        reset_mid(4'b0100);
        txn(4'b1000, (N*W)'($urandom), 1, 2, 1'b0, 1'b0);

        req_valid = '0;
        repeat (4) @(posedge CLK);
        #1 stim_done = 1'b1;
    end
endmodule

// File: doc/mbinit_sb_tx_arbiter.md
Name: mbinit_sb_tx_arbiter

Overview:
- Shares the single sideband TX message port between the MBINIT sub-step modules (PARAM, CAL, REPAIRCLK, REPAIRVAL, ...).
- Each requester presents a message plus a valid level. The arbiter grants one requester at a time (round-robin) and drives its message onto the TX port.
- It holds the grant until the sideband engine signals completion via the busy falling edge, then returns a done pulse to that requester.
- A watchdog aborts transactions that never complete.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SB_MSG_WIDTH, 4, sideband message encoding width.
- TIMEOUT_CYCLES, 1023, max cycles in WAIT_DONE before abort (>=2).

Ports:
- CLK  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- i_req_valid  in  N_REQ  per-requester request level; bit k = requester k.
- i_req_msg  in  N_REQ*SB_MSG_WIDTH  requester k message at bits [k*SB_MSG_WIDTH +: SB_MSG_WIDTH].
- i_Busy_SideBand  in  1  sideband engine busy level.
- i_falling_edge_busy  in  1  one-cycle pulse, busy 1->0.
- o_TX_SbMessage  out  SB_MSG_WIDTH  message to sideband engine.
- o_ValidOutDatat  out  1  one-cycle issue strobe.
- o_grant  out  N_REQ  one-hot current owner; 0 when idle.
- o_req_done  out  N_REQ  one-cycle pulse to the owner on completion.
- o_timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; rr pointer last_idx = N_REQ-1, so requester 0 wins first; timeout counter 0.
- States: IDLE, ISSUE, WAIT_DONE. All outputs are registered.
- IDLE:
  - If |i_req_valid and !i_Busy_SideBand: select the first set bit searching from last_idx+1 upward, wrapping modulo N_REQ.
  - Latch that requester's message into o_TX_SbMessage.
  - Next cycle: o_grant = onehot(sel), o_ValidOutDatat = 1, state = ISSUE.
  - If busy is high, or no request is present, stay in IDLE with outputs 0.
- Latency: request sampled at edge t -> strobe and grant visible in cycle t+1.
- ISSUE:
  - Lasts exactly one cycle. o_ValidOutDatat returns to 0 after it.
  - Go to WAIT_DONE; timeout counter cleared.
  - i_falling_edge_busy during ISSUE is ignored, since it belongs to prior traffic.
- WAIT_DONE:
  - o_grant and o_TX_SbMessage are held stable. The counter increments each cycle.
  - On i_falling_edge_busy: o_req_done[owner] = 1 for one cycle, o_grant = 0, last_idx = owner, state = IDLE.
  - If the counter reaches TIMEOUT_CYCLES-1 without an edge: o_timeout = 1 for one cycle, o_grant = 0, no done pulse, last_idx = owner, state = IDLE.
  - If the edge and timeout coincide, completion wins: done pulses, no timeout.
- Re-arbitration:
  - The earliest re-arbitration is the cycle after the done/timeout cycle, because IDLE samples again.
  - There is therefore at least one idle cycle between consecutive o_ValidOutDatat strobes.
- Requester protocol:
  - A requester keeps valid high until its done pulse.
  - If it drops valid mid-transaction, the transaction still completes and done still pulses.
  - Message changes after the latch have no effect.
- Fairness: a requester that keeps valid high is served at most every N_REQ grants.
- Counter width is clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- Illegal or unknown state goes to IDLE with outputs cleared.
- An rst assertion at any point aborts immediately; no done or timeout pulse is produced.

Optional Feature:
- Macro: MBINIT_SB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index always wins; last_idx is unused and not updated.
- Undefined (default): round-robin as above.

Test Plan:
- Single request: valid=4'b0010, msg1=4'h1, busy low -> cycle+1: grant=0010, TX=1, strobe 1 cycle. Falling edge 5 cycles later -> done=0010 pulse, grant=0.
- All requests: valid=4'b1111 held continuously, each completed after 3 cycles -> grant order 0001,0010,0100,1000,0001. With MBINIT_SB_ARB_FIXED_PRIO_EN -> 0001 every time.
- Busy gating: valid=0001 while busy=1 for 10 cycles -> no strobe. Busy falls -> strobe in the next cycle.
- Timeout: TIMEOUT_CYCLES=8, never pulse the edge -> o_timeout in the 8th WAIT_DONE cycle, no done, grant=0. The next arbitration starts from index owner+1.
- Edge during ISSUE: falling-edge pulse coincident with the strobe -> ignored; done occurs only on a later edge. Edge coincident with the last timeout cycle -> done, no timeout.
- Reset mid-WAIT_DONE: rst pulsed -> all outputs 0 asynchronously. After release with valid=1000, grant=1000 (last_idx reset to 3 means search starts at 0, and 0..2 are absent).
